// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port synchronous memory between instruction
//                fetch (read-only) and the load/store path (read/write).
//                Data accesses win unless fetch has been starved too long.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_stall_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,

    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,

    output logic [AW-1:0] mem_a_o,
    output logic          mem_w_o,
    output logic [DW-1:0] mem_d_o,
    input  logic [DW-1:0] mem_q_i
);

    localparam logic [1:0] c_rsp_idle  = 2'd0;
    localparam logic [1:0] c_rsp_if_rd = 2'd1;
    localparam logic [1:0] c_rsp_d_rd  = 2'd2;

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [1:0] rsp_q;
    logic [1:0] rsp_d;
    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    logic       w_starve_flag;
    logic       w_d_gnt;
    logic       w_if_gnt;

    // ------------------------------------------------------------------
    // Arbitration: data wins contention unless fetch has hit the limit.
    // Grants are suppressed while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_starve_flag = (starve_cnt_q == c_starve_max);
        w_d_gnt       = rst & d_req_i & ~(if_req_i & w_starve_flag);
        w_if_gnt      = rst & if_req_i & ~w_d_gnt;
    end

    assign if_gnt_o   = w_if_gnt;
    assign d_gnt_o    = w_d_gnt;
    assign if_stall_o = if_req_i & ~w_if_gnt;

    // Idle cycles fall through to a fetch-address read, which is harmless.
    always_comb begin
        mem_a_o = if_addr_i;
        mem_w_o = 1'b0;
        mem_d_o = '0;
        if (w_d_gnt) begin
            mem_a_o = d_addr_i;
            mem_w_o = d_we_i;
            mem_d_o = d_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_i || w_if_gnt) begin
            starve_cnt_d = 4'd0;
        end else if (w_d_gnt && !w_starve_flag) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Response-owner FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_q <= c_rsp_idle;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Next-state: the owner of the read issued this cycle; stores answer nothing.
    always_comb begin
        rsp_d = c_rsp_idle;
        if (w_if_gnt) begin
            rsp_d = c_rsp_if_rd;
        end else if (w_d_gnt && !d_we_i) begin
            rsp_d = c_rsp_d_rd;
        end
    end

    // Output decode
    always_comb begin
        if_rvalid_o = (rsp_q == c_rsp_if_rd);
        d_rvalid_o  = (rsp_q == c_rsp_d_rd);
        if_rdata_o  = if_rvalid_o ? mem_q_i : '0;
        d_rdata_o   = d_rvalid_o  ? mem_q_i : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a transaction
//                level reference model and a behavioural memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW         = 16;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o, if_stall_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i, d_we_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o, d_rvalid_o;
    logic [DW-1:0] d_rdata_o;
    logic [AW-1:0] mem_a_o;
    logic          mem_w_o;
    logic [DW-1:0] mem_d_o;
    logic [DW-1:0] mem_q_i;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_gnt_o   (if_gnt_o),
        .if_stall_o (if_stall_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_gnt_o    (d_gnt_o),
        .d_rvalid_o (d_rvalid_o),
        .d_rdata_o  (d_rdata_o),
        .mem_a_o    (mem_a_o),
        .mem_w_o    (mem_w_o),
        .mem_d_o    (mem_d_o),
        .mem_q_i    (mem_q_i)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous memory
    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_w_o) tb_mem[mem_a_o] <= mem_d_o;
        mem_q_i <= tb_mem[mem_a_o];
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            ref_wait;      // consecutive data wins while fetch waited
    int            ref_owner;     // 0 none, 1 fetch, 2 data: who gets data next cycle
    logic [DW-1:0] ref_data;
    bit            ref_known;     // response state defined only after first reset

    int n_checks = 0;
    int n_fail   = 0;
    int n_if_gnt = 0;
    int n_d_gnt  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic ifr, input logic [AW-1:0] ifa,
                        input logic dr, input logic dwe, input logic [AW-1:0] da,
                        input logic [DW-1:0] dwd);
        logic e_ifg, e_dg;
        @(negedge clk);
        rst = r; if_req_i = ifr; if_addr_i = ifa;
        d_req_i = dr; d_we_i = dwe; d_addr_i = da; d_wdata_i = dwd;
        #1;
        if (!r) begin
            e_ifg = 1'b0; e_dg = 1'b0;
        end else if (ifr && dr) begin
            e_dg  = (ref_wait < STARVE_MAX);
            e_ifg = !e_dg;
        end else begin
            e_ifg = ifr; e_dg = dr;
        end
        chk("if_gnt",   64'(if_gnt_o),   64'(e_ifg));
        chk("d_gnt",    64'(d_gnt_o),    64'(e_dg));
        chk("if_stall", 64'(if_stall_o), 64'(ifr && !e_ifg));
        chk("mem_w",    64'(mem_w_o),    64'(e_dg && dwe));
        chk("mem_a",    64'(mem_a_o),    64'(e_dg ? da : ifa));
        chk("mem_d",    64'(mem_d_o),    e_dg ? 64'(dwd) : 64'd0);
        if (ref_known) begin
            chk("if_rvalid", 64'(if_rvalid_o), 64'(ref_owner == 1));
            chk("d_rvalid",  64'(d_rvalid_o),  64'(ref_owner == 2));
            chk("if_rdata",  64'(if_rdata_o),  ref_owner == 1 ? 64'(ref_data) : 64'd0);
            chk("d_rdata",   64'(d_rdata_o),   ref_owner == 2 ? 64'(ref_data) : 64'd0);
        end
        if (e_ifg) n_if_gnt++;
        if (e_dg)  n_d_gnt++;
        // Advance the model to the state after this clock edge
        if (!r) begin
            ref_wait = 0; ref_owner = 0; ref_known = 1'b1;
        end else if (e_dg) begin
            if (dwe) begin
                ref_mem[da] = dwd; ref_owner = 0;
            end else begin
                ref_owner = 2; ref_data = ref_mem[da];
            end
            ref_wait = ifr ? ((ref_wait + 1 > STARVE_MAX) ? STARVE_MAX : ref_wait + 1) : 0;
        end else if (e_ifg) begin
            ref_owner = 1; ref_data = ref_mem[ifa]; ref_wait = 0;
        end else begin
            ref_owner = 0; ref_wait = 0;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            tb_mem[i]  = 32'hA0 + i;
            ref_mem[i] = 32'hA0 + i;
        end
        ref_wait = 0; ref_owner = 0; ref_data = '0; ref_known = 1'b0;
        rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;

        // Reset with requests pending: no grants, stall follows if_req
        step(1'b0, 1'b1, 16'h0005, 1'b1, 1'b1, 16'h0006, 32'h1111_2222);
        step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, '0, '0);
        idle(1);

        // Fetch only, consecutive addresses
        for (int a = 0; a < 4; a++) step(1'b1, 1'b1, 16'(a), 1'b0, 1'b0, '0, '0);
        idle(1);

        // Store then load of the same word
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 16'h1234, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'h1234, '0);
        idle(1);

        // Sustained contention
        for (int i = 0; i < 15; i++)
            step(1'b1, 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0, 16'(16'h0200 + i), '0);
        idle(1);

        // Alternating ownership
        step(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'h0020, '0);
        step(1'b1, 1'b1, 16'h0011, 1'b0, 1'b0, '0, '0);
        idle(1);

        // Reset asserted while a load is requested, after building up starvation
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0040, '0);
        step(1'b0, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0041, '0);
        step(1'b1, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0042, '0);
        step(1'b1, 1'b1, 16'h0030, 1'b1, 1'b0, 16'h0043, '0);
        idle(3);

        // Randomized traffic over a small address window for store/load overlap
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0), 16'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 15)), $urandom);
        end
        idle(2);

        chk("fetch_grants_seen", 64'(n_if_gnt > 0), 64'd1);
        chk("data_grants_seen",  64'(n_d_gnt > 0),  64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one synchronous single-port 32-bit x 64K memory between the instruction-fetch stage (read-only) and the execute stage's load/store path (read/write). This lets the core run with a unified instruction/data memory. The block sits between `ifetch`/`ex` and the memory instance. Data accesses have priority. A starvation counter guarantees fetch forward progress. Read data is routed back to the correct requester one cycle after grant.

## Interface
Parameters:
- `AW`, 16, address width (memory depth 2^AW words)
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (range 1..15)

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge
- `rst` input 1: synchronous, active-low reset
- `if_req_i` input 1: fetch read request
- `if_addr_i` input AW: fetch word address
- `if_gnt_o` output 1: fetch request accepted this cycle
- `if_stall_o` output 1: `if_req_i & ~if_gnt_o`, drives the ifetch stall
- `if_rvalid_o` output 1: `if_rdata_o` valid this cycle
- `if_rdata_o` output DW: fetch read data
- `d_req_i` input 1: data access request
- `d_we_i` input 1: 1 = store, 0 = load
- `d_addr_i` input AW: data word address
- `d_wdata_i` input DW: store data
- `d_gnt_o` output 1: data request accepted this cycle
- `d_rvalid_o` output 1: `d_rdata_o` valid this cycle (loads only)
- `d_rdata_o` output DW: load data
- `mem_a_o` output AW: memory address (to `A`)
- `mem_w_o` output 1: memory write enable (to `W`)
- `mem_d_o` output DW: memory write data (to `D`)
- `mem_q_i` input DW: memory read data (from `Q`), valid the cycle after the address is sampled

## Operation
- Arbitration is combinational on the current requests, the registered `starve_cnt`, and `starve_flag`.
- At most one grant per cycle.
- Priority:
  - Only one requester active: that requester is granted.
  - Both active, `starve_flag`=0: data is granted.
  - Both active, `starve_flag`=1: fetch is granted.
- Memory drive:
  - Data granted: `mem_a_o`=`d_addr_i`, `mem_w_o`=`d_we_i`, `mem_d_o`=`d_wdata_i`.
  - Otherwise: `mem_a_o`=`if_addr_i`, `mem_w_o`=0, `mem_d_o`=0.
  - Idle cycles therefore perform a harmless read.
- Response-owner state register `rsp_q`, updated every cycle:
  - IDLE: no grant, or a data store was granted.
  - IF_RD: fetch granted.
  - D_RD: data load granted.
- Response outputs (combinational from `rsp_q` and `mem_q_i`):
  - `if_rvalid_o` = (`rsp_q`==IF_RD).
  - `d_rvalid_o` = (`rsp_q`==D_RD).
  - `if_rdata_o` = `mem_q_i` when `if_rvalid_o`, else 0.
  - `d_rdata_o` = `mem_q_i` when `d_rvalid_o`, else 0.
- Starvation counter `starve_cnt` (4 bits):
  - Increments when data is granted while `if_req_i`=1, saturating at `STARVE_MAX`.
  - Clears when fetch is granted or `if_req_i`=0.
  - `starve_flag` = (`starve_cnt`==`STARVE_MAX`).
- Stores produce no response; the store is complete at the grant edge.
- Requesters hold request, address and data stable until granted. Changes while ungranted are legal; the new values are simply what gets arbitrated.

## Timing
- Grant: same cycle as the request (zero added latency) when not blocked.
- Read latency: grant in cycle N, memory samples the address at the end of N, `*_rvalid_o` and `*_rdata_o` valid in cycle N+1.
- Back-to-back grants to the same or alternating requesters: one access per cycle, full throughput, responses in grant order.
- Store in N followed by a load of the same address in N+1: the load returns the new data in N+2.
- Reset (`rst`=0 sampled at an edge):
  - `rsp_q`=IDLE, `starve_cnt`=0.
  - While `rst`=0: `if_gnt_o`=0, `d_gnt_o`=0, `mem_w_o`=0, `if_stall_o`=`if_req_i`.
  - Cycle after the reset edge: `if_rvalid_o`=`d_rvalid_o`=0, both rdata=0.
- Reset mid-operation: a read granted in the cycle reset is asserted is dropped, with no rvalid afterwards.
- Worst-case fetch wait with continuous data traffic: `STARVE_MAX` cycles, then one fetch grant.

## Test plan
- Fetch only: `if_req_i`=1, addresses 0x0000..0x0003 on consecutive cycles, memory preloaded with values 0xA0+addr.
  - Expect: `if_gnt_o`=1 every cycle, `if_rvalid_o` from cycle 2, data 0xA0..0xA3 in order, `if_stall_o`=0.
- Store then load: `d_we_i`=1, addr 0x1234, data 0xDEADBEEF in cycle 1; load 0x1234 in cycle 2.
  - Expect: `mem_w_o`=1 only in cycle 1, `d_rvalid_o`=1 with 0xDEADBEEF in cycle 3, `if_rvalid_o`=0 throughout.
- Contention: both request continuously, `STARVE_MAX`=4.
  - Expect: data granted 4 cycles, fetch granted on the 5th, pattern repeats. `if_stall_o`=1 exactly on the data-granted cycles.
- Alternating ownership: fetch read of 0x0010 and data load of 0x0020 granted on consecutive cycles.
  - Expect: each rvalid asserts only for its owner, with the correct word, one cycle after its grant.
- Reset mid-read: grant a load in cycle N and drive `rst`=0 in cycle N.
  - Expect: `d_rvalid_o`=0 in N+1, `starve_cnt`=0, no grants while `rst`=0.
- Idle: no requests for 3 cycles.
  - Expect: `mem_w_o`=0, both rvalid=0, both rdata=0, `starve_cnt`=0.
